// File: rtl/nubus_slave_resp.sv
// NuBus slave response sequencer: native memory handshake, optional wait
// states, ACK/status/read-data drive. Optional macro NUBUS_SLAVE_RESP_TIMEOUT_EN.
//
// Ports:
//   nub_clkn, reset              clock (rising edge) and async active-high reset
//   mem_valid/write/addr/wdata   slave transaction from the controller
//   mem_ready                    one-cycle done pulse back to the controller
//   ram_req/we/addr/wdata        native memory request
//   ram_rdata, ram_gnt           native read data and access complete
//   nub_ackn_o, nub_tm1n_o,
//   nub_tm0n_o                   active-low NuBus ACK and status drive
//   nub_adn_o, nub_ad_oe_o       inverted read data and its output enable
module nubus_slave_resp #(
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        nub_clkn,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        ram_req,
  output logic [3:0]  ram_we,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_gnt,
  output logic        nub_ackn_o,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic [31:0] nub_adn_o,
  output logic        nub_ad_oe_o
);

  if (WAIT_CYCLES > 15 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 255) begin : g_param_chk
    $error("nubus_slave_resp: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  we_q;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        rd_q;
  logic        tout_q;
  logic [3:0]  wait_q;
  logic        tmo;

`ifdef NUBUS_SLAVE_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt_q;

  // Fires in the last allowed REQ cycle; a grant in that cycle wins.
  assign tmo = (state_q == S_REQ) && !ram_gnt &&
               (to_cnt_q == TO_LAST);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) state_d = S_REQ;
      end
      S_REQ: begin
        if (ram_gnt) begin
          state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_ACK;
        end else if (tmo) begin
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (wait_q <= 4'd1) state_d = S_ACK;
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      tout_q   <= 1'b0;
      wait_q   <= '0;
`ifdef NUBUS_SLAVE_RESP_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            we_q     <= mem_write;
            addr_q   <= mem_addr[23:2];
            wdata_q  <= mem_wdata;
            rd_q     <= (mem_write == 4'd0);
            rdata_q  <= '0;
            tout_q   <= 1'b0;
`ifdef NUBUS_SLAVE_RESP_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        S_REQ: begin
          if (ram_gnt) begin
            if (rd_q) rdata_q <= ram_rdata;
            wait_q <= WAIT_LD;
          end else if (tmo) begin
            tout_q  <= 1'b1;
            rdata_q <= '0;
          end
`ifdef NUBUS_SLAVE_RESP_TIMEOUT_EN
          to_cnt_q <= to_cnt_q + 8'd1;
`endif
        end
        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign ram_req     = (state_q == S_REQ);
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign mem_ready   = (state_q == S_ACK);
  assign nub_ackn_o  = !mem_ready;
  assign nub_ad_oe_o = mem_ready && rd_q;
  assign nub_tm1n_o  = !(mem_ready && tout_q);
  assign nub_tm0n_o  = 1'b1;
  assign nub_adn_o   = ~rdata_q;

endmodule

// File: tb/tb_nubus_slave_resp.sv
// Bench for nubus_slave_resp: two instances (0 and 3 wait states),
// a timeline model checked every cycle, and literal spot checks.
module tb_nubus_slave_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mv0 = 1'b0, mv3 = 1'b0;
  logic        g0 = 1'b0, g3 = 1'b0;
  logic [3:0]  mwr = '0;
  logic [31:0] maddr = '0, mwd = '0, rrd = '0;

  logic        r0, q0, k0, t10, t00, oe0;
  logic [3:0]  we0;
  logic [21:0] a0;
  logic [31:0] wd0, adn0;
  logic        r3, q3, k3, t13, t03, oe3;
  logic [3:0]  we3;
  logic [21:0] a3;
  logic [31:0] wd3, adn3;

  nubus_slave_resp #(.WAIT_CYCLES(0), .TIMEOUT_CYCLES(8)) u0 (
    .nub_clkn(clk), .reset(rst), .mem_valid(mv0),
    .mem_write(mwr), .mem_addr(maddr), .mem_wdata(mwd),
    .mem_ready(r0), .ram_req(q0), .ram_we(we0),
    .ram_addr(a0), .ram_wdata(wd0), .ram_rdata(rrd),
    .ram_gnt(g0), .nub_ackn_o(k0), .nub_tm1n_o(t10),
    .nub_tm0n_o(t00), .nub_adn_o(adn0), .nub_ad_oe_o(oe0)
  );

  nubus_slave_resp #(.WAIT_CYCLES(3), .TIMEOUT_CYCLES(8)) u3 (
    .nub_clkn(clk), .reset(rst), .mem_valid(mv3),
    .mem_write(mwr), .mem_addr(maddr), .mem_wdata(mwd),
    .mem_ready(r3), .ram_req(q3), .ram_we(we3),
    .ram_addr(a3), .ram_wdata(wd3), .ram_rdata(rrd),
    .ram_gnt(g3), .nub_ackn_o(k3), .nub_tm1n_o(t13),
    .nub_tm0n_o(t03), .nub_adn_o(adn3), .nub_ad_oe_o(oe3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Expected transaction timeline (act = instance, -1 none)
  int          act = -1;
  int          req_lo, req_hi, ack_c;
  logic        e_rd, e_to;
  logic [3:0]  e_we;
  logic [21:0] e_addr;
  logic [31:0] e_wd, e_adn;
  int          ack_cnt [2];
  int          ack_at [2];
  int          last_s;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endfunction

  task automatic cmp(input int i, input logic rdy, input logic req,
                     input logic [3:0] we, input logic [21:0] ad,
                     input logic [31:0] wd, input logic ackn,
                     input logic tm1, input logic tm0,
                     input logic [31:0] adn, input logic oe);
    logic on, er, ea;
    on = (act == i);
    er = on && cyc >= req_lo && cyc <= req_hi;
    ea = on && cyc == ack_c;
    chk($sformatf("ram_req%0d", i), req, er);
    chk($sformatf("mem_ready%0d", i), rdy, ea);
    chk($sformatf("ackn%0d", i), ackn, !ea);
    chk($sformatf("oe%0d", i), oe, ea && e_rd);
    chk($sformatf("tm1n%0d", i), tm1, !(ea && e_to));
    chk($sformatf("tm0n%0d", i), tm0, 1'b1);
    if (er) begin
      chk($sformatf("ram_we%0d", i), we, e_we);
      chk($sformatf("ram_addr%0d", i), ad, e_addr);
      chk($sformatf("ram_wdata%0d", i), wd, e_wd);
    end
    if (ea) chk($sformatf("adn%0d", i), adn, e_adn);
    if (rdy) begin
      ack_cnt[i]++;
      ack_at[i] = cyc;
    end
  endtask

  always @(negedge clk) begin
    cmp(0, r0, q0, we0, a0, wd0, k0, t10, t00, adn0, oe0);
    cmp(1, r3, q3, we3, a3, wd3, k3, t13, t03, adn3, oe3);
  end

  task automatic set_mv(input int i, input logic v);
    if (i == 0) mv0 = v;
    else mv3 = v;
  endtask

  task automatic set_g(input int i, input logic v);
    if (i == 0) g0 = v;
    else g3 = v;
  endtask

  task automatic rst_chk(input int i);
    if (i == 0) begin
      chk("rst_ready0", {r0, q0, k0, t10, t00, oe0}, 6'b001110);
      chk("rst_we0", we0, 4'h0);
      chk("rst_addr0", a0, 22'h0);
      chk("rst_wd0", wd0, 32'h0);
      chk("rst_adn0", adn0, 32'hFFFFFFFF);
    end else begin
      chk("rst_ready3", {r3, q3, k3, t13, t03, oe3}, 6'b001110);
      chk("rst_we3", we3, 4'h0);
      chk("rst_addr3", a3, 22'h0);
      chk("rst_wd3", wd3, 32'h0);
      chk("rst_adn3", adn3, 32'hFFFFFFFF);
    end
  endtask

  // mode: 0 drop valid in RECOVER, 1 hold into IDLE, 2 abort in REQ
  task automatic run(input int i, input logic [3:0] wr,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic [31:0] rd, input int gdel,
                     input logic to, input int mode,
                     input logic [21:0] x_addr,
                     input logic [31:0] x_adn);
    int s, w, drop_c;
    @(posedge clk); #1;
    s = cyc;
    last_s = s;
    w = (i == 0) ? 0 : 3;
    req_lo = s + 1;
    if (to) begin
      req_hi = s + 8;
      ack_c = s + 9;
    end else begin
      req_hi = s + gdel;
      ack_c = s + gdel + w + 1;
    end
    e_rd = (wr == 4'h0);
    e_to = to;
    e_we = wr;
    e_addr = x_addr;
    e_wd = wd;
    e_adn = x_adn;
    ack_cnt[i] = 0;
    ack_at[i] = -1;
    act = i;
    drop_c = (mode == 2) ? s + 2 : (mode == 1) ? ack_c + 2 : ack_c + 1;
    mwr = wr;
    maddr = ad;
    mwd = wd;
    rrd = 32'hA5A5A5A5;
    set_mv(i, 1'b1);
    set_g(i, 1'b1);
    for (int c = s + 1; c <= ack_c + 4; c++) begin
      @(posedge clk); #1;
      set_g(i, to ? (c > req_hi) : (c >= req_hi));
      rrd = (!to && c == req_hi) ? rd : 32'hA5A5A5A5;
      if (c == drop_c) set_mv(i, 1'b0);
    end
    set_g(i, 1'b0);
    set_mv(i, 1'b0);
    act = -1;
    chk("ack_once", ack_cnt[i], 1);
    chk("ack_cycle", ack_at[i] - s, ack_c - s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_chk(0);
    rst_chk(1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(0, 4'hF, 32'hF9000010, 32'hDEADBEEF, 32'h11112222,
        1, 1'b0, 0, 22'h000004, 32'hFFFFFFFF);
    chk("w0_latency", ack_at[0] - last_s, 2);

    run(1, 4'h0, 32'h00000100, 32'h0, 32'h12345678,
        1, 1'b0, 0, 22'h000040, 32'hEDCBA987);
    chk("r3_latency", ack_at[1] - last_s, 5);

    run(0, 4'h3, 32'h00ABCDE8, 32'h0000BEEF, 32'h99999999,
        3, 1'b0, 0, 22'h2AF37A, 32'hFFFFFFFF);

    run(1, 4'h0, 32'h0000000C, 32'h0, 32'h0F0F0000,
        2, 1'b0, 1, 22'h000003, 32'hF0F0FFFF);

    run(0, 4'h0, 32'h00000020, 32'h0, 32'hCAFEF00D,
        4, 1'b0, 2, 22'h000008, 32'h35010FF2);

    run(1, 4'h1, 32'h00000004, 32'h000000AA, 32'h0,
        1, 1'b0, 2, 22'h000001, 32'hFFFFFFFF);

`ifdef NUBUS_SLAVE_RESP_TIMEOUT_EN
    run(1, 4'h0, 32'h00000008, 32'h0, 32'h0,
        0, 1'b1, 0, 22'h000002, 32'hFFFFFFFF);
    chk("to_latency", ack_at[1] - last_s, 9);
    run(0, 4'h0, 32'h00000010, 32'h0, 32'h00000001,
        8, 1'b0, 0, 22'h000004, 32'hFFFFFFFE);
`else
    run(0, 4'h0, 32'h00000010, 32'h0, 32'h80000000,
        20, 1'b0, 0, 22'h000004, 32'h7FFFFFFF);
    chk("long_latency", ack_at[0] - last_s, 21);
`endif

    // Reset in the middle of a REQ that is never granted
    @(posedge clk); #1;
    req_lo = cyc + 1;
    req_hi = cyc + 100;
    ack_c = cyc + 200;
    e_rd = 1'b1;
    e_to = 1'b0;
    e_we = 4'h0;
    e_addr = 22'h000005;
    e_wd = 32'h0;
    e_adn = 32'hFFFFFFFF;
    mwr = 4'h0;
    maddr = 32'h00000014;
    mwd = 32'h0;
    ack_cnt[0] = 0;
    act = 0;
    mv0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    act = -1;
    #1;
    rst_chk(0);
    @(posedge clk); #1;
    mv0 = 1'b0;
    rst = 1'b0;
    g0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    g0 = 1'b0;
    chk("no_ack_after_rst", ack_cnt[0], 0);

    run(0, 4'h0, 32'h00000030, 32'h0, 32'h55AA33CC,
        1, 1'b0, 0, 22'h00000C, 32'hAA55CC33);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nubus_slave_resp.md
NUBUS_SLAVE_RESP -- requirements
Module: nubus_slave_resp

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, meaning extra idle cycles inserted between memory grant and NuBus ACK (0..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, meaning maximum cycles spent waiting for ram_gnt before a timeout response (1..255).
REQ-003 Port nub_clkn  in  1  single clock; all state advances on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port mem_valid  in  1  slave transaction pending, held until mem_ready sampled.
REQ-006 Port mem_write  in  4  byte-lane write strobes; all-zero marks a read.
REQ-007 Port mem_addr  in  32  latched slave address, true polarity.
REQ-008 Port mem_wdata  in  32  write data, true polarity.
REQ-009 Port mem_ready  out  1  transaction done, returned to the slave controller.
REQ-010 Port ram_req  out  1  native memory request.
REQ-011 Port ram_we  out  4  native byte write enables.
REQ-012 Port ram_addr  out  22  word address = mem_addr[23:2].
REQ-013 Port ram_wdata  out  32  native write data.
REQ-014 Port ram_rdata  in  32  native read data, valid with ram_gnt.
REQ-015 Port ram_gnt  in  1  native access complete.
REQ-016 Port nub_ackn_o  out  1  NuBus ACK drive, active-low.
REQ-017 Port nub_tm1n_o, nub_tm0n_o  out  1 each  NuBus status drive during ACK, active-low.
REQ-018 Port nub_adn_o  out  32  inverted read data for NuBus AD lines.
REQ-019 Port nub_ad_oe_o  out  1  AD output enable, read ACK cycle only.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT, ACK, RECOVER.
REQ-021 IDLE -> REQ when mem_valid=1; ram_we, ram_addr, ram_wdata captured on that edge and held stable through REQ.
REQ-022 REQ: ram_req=1; on ram_gnt=1 capture ram_rdata (reads only), go WAIT if WAIT_CYCLES>0 else ACK.
REQ-023 WAIT: 4-bit counter loaded with WAIT_CYCLES on entry, decrements each cycle; at 1 go ACK; exactly WAIT_CYCLES cycles spent in WAIT.
REQ-024 ACK lasts exactly one cycle: mem_ready=1, nub_ackn_o=0; nub_ad_oe_o=1 only for a read; then RECOVER unconditionally.
REQ-025 RECOVER lasts one cycle, ignores mem_valid, then IDLE; prevents re-triggering on a mem_valid still high from the acked transaction.
REQ-026 Status in ACK: complete = tm1n_o=1, tm0n_o=1; timeout = tm1n_o=0, tm0n_o=1; outside ACK both SHALL be 1.
REQ-027 nub_adn_o SHALL equal ~captured read data; captured data SHALL be zeroed on a timeout.
REQ-028 Latency, no wait/timeout: grant sampled in cycle N gives ACK in cycle N+1; minimum IDLE-to-ACK is 2 cycles (grant in first REQ cycle).
REQ-029 ram_gnt outside REQ SHALL be ignored.
REQ-030 mem_valid dropping while in REQ/WAIT (bus abort) SHALL not cancel the memory access; ACK still issued once.

Reset
REQ-031 Reset SHALL force IDLE, mem_ready=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, nub_ackn_o=1, nub_tm1n_o=1, nub_tm0n_o=1, nub_adn_o=all ones, nub_ad_oe_o=0, counters 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it immediately, with no ACK issued after release.

Configuration
REQ-033 Macro NUBUS_SLAVE_RESP_TIMEOUT_EN defined: 8-bit counter cleared on REQ entry, increments per REQ cycle; reaching TIMEOUT_CYCLES without ram_gnt drops ram_req and goes ACK with timeout status.
REQ-034 Macro undefined: no timeout counter; REQ waits indefinitely for ram_gnt; status always complete.
REQ-035 Grant and timeout in the same cycle SHALL resolve as grant (complete).

Verification
REQ-036 Write mem_write=4'hF, addr 0xF9000010, wdata 0xDEADBEEF, gnt in first REQ cycle, WAIT_CYCLES=0 -> ram_we=F, ram_addr=0x000004, single ACK 2 cycles after mem_valid, nub_ad_oe_o=0.
REQ-037 Read, ram_rdata=0x12345678, WAIT_CYCLES=3 -> 3 WAIT cycles, then ACK with nub_adn_o=0xEDCBA987, nub_ad_oe_o=1, status 11.
REQ-038 Timeout enabled, TIMEOUT_CYCLES=8, no gnt -> ram_req low after 8 cycles, ACK with tm1n_o=0, tm0n_o=1, nub_adn_o=all ones.
REQ-039 mem_valid held high through ACK and RECOVER -> exactly one ram_req sequence, next request only from IDLE.
REQ-040 Reset pulsed during REQ -> all outputs at REQ-031 values immediately, no ACK after release.
